// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for an RV32I core.
// Walks each instruction through FETCH -> DECODE -> EXEC -> MEM -> WB.
// It owns the PC, the instruction register and the retire counter.
// It traps on illegal or system opcodes, misaligned next-PC values and
// memory handshakes that never complete.
module core_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          DECODE_CYCLES = 1,
  parameter int          MEM_TIMEOUT   = 255
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic        oImemReq,
  output logic [31:0] oImemAddr,
  input  logic        iImemAck,
  input  logic [31:0] iImemData,
  output logic [31:0] oInst,
  output logic        oDecEn,
  input  logic [6:0]  iOpcode,
  output logic        oAluEn,
  input  logic        iBranchTaken,
  input  logic [31:0] iBranchTarget,
  output logic        oDmemReq,
  output logic        oDmemWe,
  input  logic        iDmemAck,
  output logic        oRdWe,
  input  logic        iHalt,
  output logic [2:0]  oState,
  output logic        oTrap,
  output logic [2:0]  oTrapCause,
  output logic [31:0] oRetired
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DEC_W  = $clog2(DECODE_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECODE_CYCLES - 1);

  localparam logic [2:0] CAUSE_TIMEOUT   = 3'd1;
  localparam logic [2:0] CAUSE_ILLEGAL   = 3'd2;
  localparam logic [2:0] CAUSE_MISALIGN  = 3'd3;
  localparam logic [2:0] CAUSE_ECALL     = 3'd4;

  state_t              state, state_next;
  logic [31:0]         pc, inst, target, retired;
  logic [31:0]         pc_plus4, pc_cand;
  logic [6:0]          op;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DEC_W-1:0]    dec_cnt;
  logic                trap, finish, retire, pc_load, trap_set;
  logic [2:0]          cause, trap_code;

  assign pc_plus4 = pc + 32'd4;

  // State register; reset drops every state-decoded strobe immediately.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= S_RESET;
    else      state <= state_next;
  end

  // Next-state, strobes and the PC/retire/trap decisions for this cycle.
  always_comb begin
    state_next = state;
    oImemReq   = 1'b0;
    oDecEn     = 1'b0;
    oAluEn     = 1'b0;
    oDmemReq   = 1'b0;
    oDmemWe    = 1'b0;
    oRdWe      = 1'b0;
    finish     = 1'b0;
    pc_cand    = pc_plus4;
    retire     = 1'b0;
    pc_load    = 1'b0;
    trap_set   = 1'b0;
    trap_code  = 3'd0;
    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        oImemReq = 1'b1;
        if (iImemAck) begin
          state_next = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          trap_set   = 1'b1;
          trap_code  = CAUSE_TIMEOUT;
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        oDecEn = (dec_cnt == '0);
        if (dec_cnt == DEC_LAST) begin
          if (iOpcode inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                              OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE}) begin
            state_next = S_EXEC;
          end else begin
            trap_set   = 1'b1;
            trap_code  = (iOpcode == OP_SYSTEM) ? CAUSE_ECALL : CAUSE_ILLEGAL;
            state_next = S_TRAP;
          end
        end
      end
      S_EXEC: begin
        oAluEn = 1'b1;
        if (op == OP_LOAD || op == OP_STORE) begin
          state_next = S_MEM;
        end else if (op == OP_BRANCH) begin
          pc_cand = iBranchTaken ? iBranchTarget : pc_plus4;
          finish  = 1'b1;
        end else if (op == OP_FENCE) begin
          finish = 1'b1;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        oDmemReq = 1'b1;
        oDmemWe  = (op == OP_STORE);
        if (iDmemAck) begin
          if (op == OP_STORE) finish = 1'b1;
          else                state_next = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          trap_set   = 1'b1;
          trap_code  = CAUSE_TIMEOUT;
          state_next = S_TRAP;
        end
      end
      S_WB: begin
        oRdWe   = 1'b1;
        pc_cand = (op == OP_JAL || op == OP_JALR) ? target : pc_plus4;
        finish  = 1'b1;
      end
      S_HALT: if (!iHalt) state_next = S_FETCH;
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_RESET;
    endcase
    // A misaligned next PC aborts the instruction before it retires.
    if (finish) begin
      if (pc_cand[1:0] != 2'b00) begin
        trap_set   = 1'b1;
        trap_code  = CAUSE_MISALIGN;
        state_next = S_TRAP;
      end else begin
        pc_load    = 1'b1;
        retire     = 1'b1;
        state_next = iHalt ? S_HALT : S_FETCH;
      end
    end
  end

  // Handshake wait counter and decode dwell counter.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wait_cnt <= '0;
      dec_cnt  <= '0;
    end else begin
      wait_cnt <= ((state == S_FETCH && !iImemAck) || (state == S_MEM && !iDmemAck))
                  ? wait_cnt + 1'b1 : '0;
      dec_cnt  <= (state == S_DECODE && state_next == S_DECODE) ? dec_cnt + 1'b1 : '0;
    end
  end

  // Instruction register, latched opcode and jump target.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      inst   <= 32'h0000_0013;
      op     <= 7'd0;
      target <= 32'd0;
    end else begin
      if (state == S_FETCH && iImemAck) inst <= iImemData;
      if (state == S_DECODE && state_next == S_EXEC) op <= iOpcode;
      if (state == S_EXEC) target <= iBranchTarget;
    end
  end

  // Architectural PC, retire count and sticky trap status.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pc      <= RESET_PC;
      retired <= 32'd0;
      trap    <= 1'b0;
      cause   <= 3'd0;
    end else begin
      if (pc_load) pc <= pc_cand;
      if (retire)  retired <= retired + 32'd1;
      if (trap_set) begin
        trap  <= 1'b1;
        cause <= trap_code;
      end
    end
  end

  assign oImemAddr  = pc;
  assign oInst      = inst;
  assign oState     = state;
  assign oTrap      = trap;
  assign oTrapCause = cause;
  assign oRetired   = retired;

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer: directed spec scenarios followed by random
// instructions, each checked against an instruction-level reference model.
module tb_core_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          DC  = 2;
  localparam int          MT  = 8;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        oImemReq, iImemAck = 1'b0;
  logic [31:0] oImemAddr, iImemData = 32'd0, oInst;
  logic        oDecEn, oAluEn, iBranchTaken = 1'b0;
  logic [6:0]  iOpcode;
  logic [31:0] iBranchTarget = 32'd0;
  logic        oDmemReq, oDmemWe, iDmemAck = 1'b0, oRdWe, iHalt = 1'b0;
  logic [2:0]  oState, oTrapCause;
  logic        oTrap;
  logic [31:0] oRetired;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_ret, m_inst;

  typedef struct {
    int          ni, nd, na, nm, nw, nr;
    logic        trap;
    logic [2:0]  cause;
    logic [31:0] npc;
    logic        halted;
  } exp_t;

  core_sequencer #(.RESET_PC(RPC), .DECODE_CYCLES(DC), .MEM_TIMEOUT(MT)) dut (
    .iClk(iClk), .iRst(iRst),
    .oImemReq(oImemReq), .oImemAddr(oImemAddr), .iImemAck(iImemAck), .iImemData(iImemData),
    .oInst(oInst), .oDecEn(oDecEn), .iOpcode(iOpcode), .oAluEn(oAluEn),
    .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oDmemReq(oDmemReq), .oDmemWe(oDmemWe), .iDmemAck(iDmemAck), .oRdWe(oRdWe),
    .iHalt(iHalt), .oState(oState), .oTrap(oTrap), .oTrapCause(oTrapCause),
    .oRetired(oRetired)
  );

  // Decoder stand-in: opcode field of the latched instruction.
  assign iOpcode = oInst[6:0];

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};
  endfunction

  // Instruction-level expectation: handshake lengths, strobe counts, outcome.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                 input int di, input int dd, input logic taken,
                                 input logic [31:0] tgt, input logic halt);
    exp_t e;
    logic [6:0]  op;
    logic [31:0] np;
    e = '{ni:0, nd:0, na:0, nm:0, nw:0, nr:0, trap:1'b0, cause:3'd0, npc:pc, halted:1'b0};
    op = inst[6:0];
    if (di + 1 > MT) begin
      e.ni = MT; e.trap = 1'b1; e.cause = 3'd1; return e;
    end
    e.ni = di + 1;
    e.nd = 1;
    if (op == 7'h73) begin e.trap = 1'b1; e.cause = 3'd4; return e; end
    if (!is_legal(op)) begin e.trap = 1'b1; e.cause = 3'd2; return e; end
    e.na = 1;
    np = pc + 32'd4;
    if (op == 7'h03 || op == 7'h23) begin
      if (dd + 1 > MT) begin
        e.nm = MT; e.nw = (op == 7'h23) ? MT : 0;
        e.trap = 1'b1; e.cause = 3'd1; return e;
      end
      e.nm = dd + 1;
      e.nw = (op == 7'h23) ? dd + 1 : 0;
      e.nr = (op == 7'h03) ? 1 : 0;
    end else if (op == 7'h63) begin
      if (taken) np = tgt;
    end else if (op == 7'h0F) begin
      e.nr = 0;
    end else if (op == 7'h6F || op == 7'h67) begin
      e.nr = 1; np = tgt;
    end else begin
      e.nr = 1;
    end
    if (np[1:0] != 2'b00) begin e.trap = 1'b1; e.cause = 3'd3; return e; end
    e.npc = np;
    e.halted = halt;
    return e;
  endfunction

  // Asynchronous reset pulse between clock edges; checks outputs while held.
  task automatic apply_reset();
    @(negedge iClk);
    iImemAck = 1'b0; iDmemAck = 1'b0; iHalt = 1'b0;
    #2 iRst = 1'b1;
    #1;
    check("rst_state", 32'(oState), 32'd0);
    check("rst_strobes", {26'd0, oImemReq, oDecEn, oAluEn, oDmemReq, oDmemWe, oRdWe}, 32'd0);
    check("rst_trap", {28'd0, oTrap, oTrapCause}, 32'd0);
    check("rst_retired", oRetired, 32'd0);
    check("rst_inst", oInst, 32'h0000_0013);
    check("rst_pc", oImemAddr, RPC);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    check("rst_to_fetch", 32'(oState), 32'd1);
    m_pc = RPC; m_ret = 32'd0; m_inst = 32'h0000_0013;
  endtask

  // Runs one instruction from FETCH until it is back at FETCH/HALT or trapped.
  task automatic do_instr(input logic [31:0] inst, input int di, input int dd,
                          input logic taken, input logic [31:0] tgt, input logic halt);
    exp_t e;
    int ni = 0, nd = 0, na = 0, nm = 0, nw = 0, nr = 0, cyc = 0;
    bit left = 0, done = 0;
    e = model(inst, m_pc, di, dd, taken, tgt, halt);
    iImemData = inst; iBranchTaken = taken; iBranchTarget = tgt; iHalt = halt;
    while (!done && cyc < 100) begin
      if (oImemReq) begin iImemAck = (ni == di); ni++; end else iImemAck = 1'b0;
      if (oDmemReq) begin iDmemAck = (nm == dd); nm++; if (oDmemWe) nw++; end
      else iDmemAck = 1'b0;
      if (oDecEn) nd++;
      if (oAluEn) na++;
      if (oRdWe)  nr++;
      @(negedge iClk);
      cyc++;
      if (oState != 3'd1) left = 1;
      if (left && (oState == 3'd1 || oState == 3'd6 || oState == 3'd7)) done = 1;
    end
    iImemAck = 1'b0; iDmemAck = 1'b0;
    check("instr_completes", 32'(done), 32'd1);
    if (!e.trap || e.cause != 3'd1 || e.nd != 0) m_inst = (e.ni <= MT && di < MT) ? inst : m_inst;
    if (!e.trap) begin m_pc = e.npc; m_ret = m_ret + 32'd1; end
    check("imem_req_cycles", ni, e.ni);
    check("dec_en_pulses", nd, e.nd);
    check("alu_en_pulses", na, e.na);
    check("dmem_req_cycles", nm, e.nm);
    check("dmem_we_cycles", nw, e.nw);
    check("rd_we_pulses", nr, e.nr);
    check("end_state", 32'(oState), e.trap ? 32'd7 : (e.halted ? 32'd6 : 32'd1));
    check("trap_flag", 32'(oTrap), 32'(e.trap));
    check("trap_cause", 32'(oTrapCause), 32'(e.cause));
    check("retired", oRetired, m_ret);
    check("inst_reg", oInst, m_inst);
    check("pc", oImemAddr, m_pc);
    if (e.trap) begin
      // Trap is terminal: stray acks and halts change nothing.
      for (int k = 0; k < 3; k++) begin
        iImemAck = 1'b1; iDmemAck = 1'b1; iHalt = k[0];
        @(negedge iClk);
        check("trap_strobes", {26'd0, oImemReq, oDecEn, oAluEn, oDmemReq, oDmemWe, oRdWe}, 32'd0);
        check("trap_sticky", {28'd0, oTrap, oTrapCause}, {28'd1, e.cause});
        check("trap_state", 32'(oState), 32'd7);
      end
      apply_reset();
    end else if (e.halted) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge iClk);
        check("halt_state", 32'(oState), 32'd6);
        check("halt_no_req", 32'(oImemReq), 32'd0);
      end
      iHalt = 1'b0;
      @(negedge iClk);
      check("halt_release", 32'(oState), 32'd1);
      check("halt_release_pc", oImemAddr, m_pc);
    end
    iHalt = 1'b0;
  endtask

  initial begin
    logic [31:0] r, inst, tgt;
    logic [6:0]  op;
    logic [6:0]  ops [12];
    int di, dd;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};
    m_pc = RPC; m_ret = 32'd0; m_inst = 32'h0000_0013;
    repeat (2) @(negedge iClk);
    apply_reset();

    // addi, fetch ack two cycles after request
    do_instr(32'h0050_0093, 2, 0, 1'b0, 32'd0, 1'b0);
    // lw with a 3-cycle data wait, then sw
    do_instr(32'h0000_A103, 0, 3, 1'b0, 32'd0, 1'b0);
    do_instr(32'h0020_A023, 1, 1, 1'b0, 32'd0, 1'b0);
    // taken beq to an aligned, then a misaligned target
    do_instr(32'h0000_0063, 0, 0, 1'b1, 32'h0000_0100, 1'b0);
    do_instr(32'h0000_0063, 0, 0, 1'b1, 32'h0000_0102, 1'b0);
    // illegal opcode and ecall
    do_instr(32'h0000_007F, 0, 0, 1'b0, 32'd0, 1'b0);
    do_instr(32'h0000_0073, 1, 0, 1'b0, 32'd0, 1'b0);
    // fetch never acknowledged
    do_instr(32'h0050_0093, 50, 0, 1'b0, 32'd0, 1'b0);

    // reset asserted while waiting in MEM
    iImemData = 32'h0000_A103;
    for (int k = 0; k < 20 && oState != 3'd4; k++) begin
      iImemAck = oImemReq; iDmemAck = 1'b0;
      @(negedge iClk);
    end
    iImemAck = 1'b0;
    check("reached_mem", 32'(oState), 32'd4);
    check("mem_req_high", 32'(oDmemReq), 32'd1);
    apply_reset();

    // halt requested across an addi
    do_instr(32'h0050_0093, 0, 0, 1'b0, 32'd0, 1'b1);
    do_instr(32'h0050_0093, 1, 0, 1'b0, 32'd0, 1'b0);

    // random instruction stream
    for (int n = 0; n < 60; n++) begin
      r  = $urandom();
      op = ops[$urandom_range(0, 11)];
      if (op == 7'h00) begin
        op = r[6:0];
        while (is_legal(op) || op == 7'h73) op = 7'($urandom());
      end
      inst = {r[31:7], op};
      di = ($urandom_range(0, 9) == 0) ? MT + 1 : $urandom_range(0, 3);
      dd = ($urandom_range(0, 9) == 0) ? MT + 2 : $urandom_range(0, 3);
      tgt = $urandom();
      if (op == 7'h63 && $urandom_range(0, 4) == 0) tgt[1:0] = 2'b10;
      else tgt[1:0] = 2'b00;
      do_instr(inst, di, dd, 1'($urandom()), tgt, ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
